// File: rtl/text_ram_arbiter_if.sv
// Requester-side bus of the text RAM arbiter: display scan reads, parser
// read/write accesses and the bulk-fill command, grouped into one interface.
interface text_ram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;

    logic              prs_req;
    logic              prs_we;
    logic [ADDR_W-1:0] prs_addr;
    logic [DATA_W-1:0] prs_wdata;
    logic              prs_gnt;
    logic              prs_rvalid;

    logic [DATA_W-1:0] rdata;

    logic              fill_start;
    logic [ADDR_W-1:0] fill_base;
    logic [ADDR_W:0]   fill_count;
    logic [DATA_W-1:0] fill_data;
    logic              fill_busy;
    logic              fill_done;

    modport master (
        output disp_req, disp_addr,
        output prs_req, prs_we, prs_addr, prs_wdata,
        output fill_start, fill_base, fill_count, fill_data,
        input  disp_gnt, disp_rvalid, prs_gnt, prs_rvalid, rdata,
        input  fill_busy, fill_done
    );

    modport slave (
        input  disp_req, disp_addr,
        input  prs_req, prs_we, prs_addr, prs_wdata,
        input  fill_start, fill_base, fill_count, fill_data,
        output disp_gnt, disp_rvalid, prs_gnt, prs_rvalid, rdata,
        output fill_busy, fill_done
    );
endinterface

// File: rtl/text_ram_arbiter.sv
// Text RAM arbiter: shares one single-port text-cell RAM (read latency 1)
// between the display scan-out, a bulk-fill engine and the text parser.
// Base priority display > fill > parser; grants are combinational.
// Optional macro TEXT_RAM_ARB_FAIRNESS_EN: after STARVE_LIMIT consecutive
// display grants with fill/parser waiting, one slot is handed to fill (first)
// or the parser. Without it, arbitration is strict priority.
module text_ram_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    text_ram_arbiter_if.slave   bus,
    output logic                ram_en_o,
    output logic                ram_we_o,
    output logic [ADDR_W-1:0]   ram_addr_o,
    output logic [DATA_W-1:0]   ram_wdata_o,
    input  logic [DATA_W-1:0]   ram_rdata_i
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] faddr_q, faddr_d;
    logic [ADDR_W:0]   fcnt_q, fcnt_d;
    logic [DATA_W-1:0] fdata_q, fdata_d;
    logic              done_q, done_d;
    logic              disp_rv_q, prs_rv_q;

    logic fill_pend, prs_pend, force_alt;
    logic disp_gnt, fill_gnt, prs_gnt;

`ifdef TEXT_RAM_ARB_FAIRNESS_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q, starve_d;

    // Count display grants taken while someone else is waiting; clear otherwise
    always_comb begin
        starve_d = '0;
        if (disp_gnt && (fill_pend || prs_pend))
            starve_d = starve_q + SW'(1);
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end

    assign force_alt = (starve_q >= SW'(STARVE_LIMIT));
`else
    assign force_alt = 1'b0;
`endif

    // Arbitration: parser is fenced off during a fill and in the fill_start cycle
    always_comb begin
        fill_pend = (state_q == FILL);
        prs_pend  = bus.prs_req && (state_q == IDLE) && !bus.fill_start;
        disp_gnt  = 1'b0;
        fill_gnt  = 1'b0;
        prs_gnt   = 1'b0;
        if (!rst) begin
            if (force_alt && fill_pend)      fill_gnt = 1'b1;
            else if (force_alt && prs_pend)  prs_gnt  = 1'b1;
            else if (bus.disp_req)           disp_gnt = 1'b1;
            else if (fill_pend)              fill_gnt = 1'b1;
            else if (prs_pend)               prs_gnt  = 1'b1;
        end
    end

    // Fill FSM state register and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Fill engine address/count/data registers (qualified by state, no reset)
    always_ff @(posedge clk) begin
        faddr_q <= faddr_d;
        fcnt_q  <= fcnt_d;
        fdata_q <= fdata_d;
    end

    // Fill FSM next state: latch command in IDLE, step one cell per fill grant
    always_comb begin
        state_d = state_q;
        faddr_d = faddr_q;
        fcnt_d  = fcnt_q;
        fdata_d = fdata_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.fill_start) begin
                    faddr_d = bus.fill_base;
                    fcnt_d  = bus.fill_count;
                    fdata_d = bus.fill_data;
                    if (bus.fill_count == '0) done_d  = 1'b1;
                    else                      state_d = FILL;
                end
            end
            FILL: begin
                if (fill_gnt) begin
                    faddr_d = faddr_q + ADDR_W'(1);
                    fcnt_d  = fcnt_q - (ADDR_W+1)'(1);
                    if (fcnt_q == (ADDR_W+1)'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read-valid tracking: one cycle after a read grant
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_rv_q <= 1'b0;
            prs_rv_q  <= 1'b0;
        end else begin
            disp_rv_q <= disp_gnt;
            prs_rv_q  <= prs_gnt && !bus.prs_we;
        end
    end

    // Outputs: grants, status, and the RAM port muxed from the winner
    always_comb begin
        bus.disp_gnt    = disp_gnt;
        bus.prs_gnt     = prs_gnt;
        bus.disp_rvalid = disp_rv_q;
        bus.prs_rvalid  = prs_rv_q;
        bus.rdata       = (disp_rv_q || prs_rv_q) ? ram_rdata_i : '0;
        bus.fill_busy   = (state_q == FILL);
        bus.fill_done   = done_q;
        ram_en_o        = disp_gnt || fill_gnt || prs_gnt;
        ram_we_o        = fill_gnt || (prs_gnt && bus.prs_we);
        ram_addr_o      = '0;
        ram_wdata_o     = '0;
        if (disp_gnt)      ram_addr_o = bus.disp_addr;
        else if (fill_gnt) ram_addr_o = faddr_q;
        else if (prs_gnt)  ram_addr_o = bus.prs_addr;
        if (fill_gnt)                   ram_wdata_o = fdata_q;
        else if (prs_gnt && bus.prs_we) ram_wdata_o = bus.prs_wdata;
    end

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Directed bench for text_ram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_text_ram_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] mem [0:4095];
    int            wr_cnt;

    int n_chk;
    int n_err;
    int w0;
    int ndisp;
    int pidx;
    int dseen;
    logic [AW-1:0] ea;

    text_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    text_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM model, read latency 1, plus a bench-only preload port
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                wr_cnt        <= wr_cnt + 1;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_err = 0; wr_cnt = 0; ram_rdata = '0;
        rst = 1'b1;
        bus.disp_req = 0; bus.disp_addr = '0;
        bus.prs_req = 0; bus.prs_we = 0; bus.prs_addr = '0; bus.prs_wdata = '0;
        bus.fill_start = 0; bus.fill_base = '0; bus.fill_count = '0; bus.fill_data = '0;
        pre_we = 1'b1; pre_addr = 12'h005; pre_data = 32'hA5;
        cyc();
        pre_addr = 12'h010; pre_data = 32'h1234;
        cyc();
        pre_we = 1'b0;
        cyc();

        // Reset state
        chk("rst_disp_gnt", 64'(bus.disp_gnt), 64'd0);
        chk("rst_prs_gnt", 64'(bus.prs_gnt), 64'd0);
        chk("rst_rvalid", 64'({bus.disp_rvalid, bus.prs_rvalid}), 64'd0);
        chk("rst_ram_en_we", 64'({ram_en, ram_we}), 64'd0);
        chk("rst_fill", 64'({bus.fill_busy, bus.fill_done}), 64'd0);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_ram_wdata", 64'(ram_wdata), 64'd0);

        // Parser read of 0x005 with idle display
        rst = 1'b0;
        bus.prs_req = 1; bus.prs_we = 0; bus.prs_addr = 12'h005;
        #1;
        chk("prd_gnt", 64'(bus.prs_gnt), 64'd1);
        chk("prd_addr", 64'(ram_addr), 64'h005);
        chk("prd_en_we", 64'({ram_en, ram_we}), 64'b10);
        cyc();
        bus.prs_req = 0;
        #1;
        chk("prd_rvalid", 64'(bus.prs_rvalid), 64'd1);
        chk("prd_rdata", 64'(bus.rdata), 64'hA5);
        chk("prd_no_disp_rv", 64'(bus.disp_rvalid), 64'd0);

        // Display read and parser write in the same cycle
        cyc();
        w0 = wr_cnt;
        bus.disp_req = 1; bus.disp_addr = 12'h010;
        bus.prs_req = 1; bus.prs_we = 1; bus.prs_addr = 12'h020; bus.prs_wdata = 32'hDEADBEEF;
        #1;
        chk("dp_disp_first", 64'({bus.disp_gnt, bus.prs_gnt}), 64'b10);
        chk("dp_disp_addr", 64'(ram_addr), 64'h010);
        cyc();
        bus.disp_req = 0;
        #1;
        chk("dp_prs_next", 64'({bus.disp_gnt, bus.prs_gnt, ram_we}), 64'b011);
        chk("dp_wdata", 64'(ram_wdata), 64'hDEADBEEF);
        chk("dp_disp_rv", 64'({bus.disp_rvalid, bus.rdata}), {31'd0, 1'b1, 32'h1234});
        cyc();
        bus.prs_req = 0; bus.prs_we = 0;
        #1;
        chk("dp_wr_no_rv", 64'(bus.prs_rvalid), 64'd0);
        chk("dp_mem", 64'(mem[12'h020]), 64'hDEADBEEF);
        chk("dp_one_write", 64'(wr_cnt - w0), 64'd1);

        // Wrapping fill with the parser waiting; restart attempt mid-fill
        cyc();
        w0 = wr_cnt;
        bus.fill_start = 1; bus.fill_base = 12'hFFE; bus.fill_count = 13'd4; bus.fill_data = 32'h20;
        bus.prs_req = 1; bus.prs_we = 0; bus.prs_addr = 12'h005;
        #1;
        chk("f_start_prs_blk", 64'({bus.prs_gnt, ram_en, bus.fill_busy}), 64'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            bus.fill_start = (i == 1);
            if (i == 1) begin
                bus.fill_base = 12'h100; bus.fill_count = 13'd9;
            end
            #1;
            ea = 12'hFFE + 12'(i);
            chk("f_busy", 64'(bus.fill_busy), 64'd1);
            chk("f_addr", 64'(ram_addr), 64'(ea));
            chk("f_we_data", 64'({ram_we, ram_wdata}), {31'd0, 1'b1, 32'h20});
            chk("f_prs_held", 64'(bus.prs_gnt), 64'd0);
        end
        cyc();
        bus.fill_start = 0;
        #1;
        chk("f_done", 64'({bus.fill_done, bus.fill_busy}), 64'b10);
        chk("f_prs_after", 64'(bus.prs_gnt), 64'd1);
        chk("f_write_cnt", 64'(wr_cnt - w0), 64'd4);
        chk("f_mem_fff", 64'(mem[12'hFFF]), 64'h20);
        chk("f_mem_001", 64'(mem[12'h001]), 64'h20);
        cyc();
        bus.prs_req = 0;
        #1;
        chk("f_prs_rdata", 64'({bus.prs_rvalid, bus.rdata}), {31'd0, 1'b1, 32'hA5});
        chk("f_done_pulse", 64'(bus.fill_done), 64'd0);

        // Zero-length fill
        cyc();
        w0 = wr_cnt;
        bus.fill_start = 1; bus.fill_base = 12'h300; bus.fill_count = 13'd0;
        #1;
        chk("z_no_en", 64'(ram_en), 64'd0);
        cyc();
        bus.fill_start = 0;
        #1;
        chk("z_done", 64'({bus.fill_done, bus.fill_busy, ram_en}), 64'b100);
        cyc();
        chk("z_after", 64'({bus.fill_done, bus.fill_busy}), 64'd0);
        chk("z_no_write", 64'(wr_cnt - w0), 64'd0);

        // Display takes priority over an active fill
        cyc();
        bus.fill_start = 1; bus.fill_base = 12'h040; bus.fill_count = 13'd2; bus.fill_data = 32'h7;
        cyc();
        bus.fill_start = 0; bus.disp_req = 1; bus.disp_addr = 12'h010;
        #1;
        chk("df_disp_wins", 64'({bus.disp_gnt, ram_we, bus.fill_busy}), 64'b101);
        cyc();
        bus.disp_req = 0;
        #1;
        chk("df_fill_0", 64'({ram_we, ram_addr}), {51'd0, 1'b1, 12'h040});
        cyc();
        chk("df_fill_1", 64'({ram_we, ram_addr}), {51'd0, 1'b1, 12'h041});
        cyc();
        chk("df_done", 64'(bus.fill_done), 64'd1);

        // Display held high continuously with a parser read pending
        cyc();
        bus.disp_req = 1; bus.disp_addr = 12'h010;
        bus.prs_req = 1; bus.prs_we = 0; bus.prs_addr = 12'h005;
        ndisp = 0; pidx = -1;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (bus.prs_gnt && pidx < 0) pidx = i;
            if (bus.disp_gnt && pidx < 0) ndisp++;
            cyc();
            if (pidx >= 0) bus.prs_req = 0;
        end
`ifdef TEXT_RAM_ARB_FAIRNESS_EN
        chk("fair_prs_slot", 64'(pidx), 64'd4);
        chk("fair_disp_cnt", 64'(ndisp), 64'd4);
`else
        chk("strict_no_prs", 64'(pidx >= 0), 64'd0);
        chk("strict_disp_cnt", 64'(ndisp), 64'd12);
`endif
        bus.disp_req = 0; bus.prs_req = 0;

        // Reset after the 2nd write of an 8-cell fill
        cyc();
        w0 = wr_cnt;
        bus.fill_start = 1; bus.fill_base = 12'h200; bus.fill_count = 13'd8; bus.fill_data = 32'h55;
        cyc();
        bus.fill_start = 0;
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("ra_two_writes", 64'(wr_cnt - w0), 64'd2);
        chk("ra_no_en_in_rst", 64'(ram_en), 64'd0);
        cyc();
        rst = 1'b0;
        chk("ra_fill_flags", 64'({bus.fill_busy, bus.fill_done}), 64'd0);
        chk("ra_rv", 64'({bus.disp_rvalid, bus.prs_rvalid, bus.rdata}), 64'd0);
        chk("ra_ram", 64'({ram_en, ram_we, ram_addr, ram_wdata}), 64'd0);
        dseen = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (bus.fill_done || bus.fill_busy) dseen++;
        end
        chk("ra_no_done", 64'(dseen), 64'd0);
        chk("ra_no_more_wr", 64'(wr_cnt - w0), 64'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/text_ram_arbiter.md
TEXT_RAM_ARBITER -- requirements
Module: text_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, text-cell address width (80x30 = 2400 cells).
REQ-002 Parameter DATA_W, default 32, text-cell word width (glyph plus attributes).
REQ-003 Parameter STARVE_LIMIT, default 4, maximum consecutive display grants while a lower requester waits.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 disp_req  in  1, disp_addr  in  ADDR_W: display scan read request, held until granted.
REQ-007 disp_gnt  out  1, disp_rvalid  out  1: grant pulse, then read-data-valid pulse.
REQ-008 prs_req  in  1, prs_we  in  1, prs_addr  in  ADDR_W, prs_wdata  in  DATA_W: parser read/write request, held until granted.
REQ-009 prs_gnt  out  1, prs_rvalid  out  1: parser grant pulse and read-data-valid pulse.
REQ-010 rdata  out  DATA_W: shared read data, qualified by disp_rvalid or prs_rvalid.
REQ-011 fill_start  in  1, fill_base  in  ADDR_W, fill_count  in  ADDR_W+1, fill_data  in  DATA_W: bulk-fill command (clear/erase).
REQ-012 fill_busy  out  1, fill_done  out  1: fill in progress; one-cycle completion pulse.
REQ-013 ram_en, ram_we  out  1; ram_addr  out  ADDR_W; ram_wdata  out  DATA_W; ram_rdata  in  DATA_W: single-port RAM, read latency 1.

Function
REQ-014 At most one RAM access is issued per cycle; ram_en is high exactly in cycles where a grant is issued.
REQ-015 Grants are combinational from the current requests; gnt is high for one cycle, and the requester drops or changes its request in the following cycle.
REQ-016 Base priority: display > fill engine > parser.
REQ-017 No prs_gnt while fill_busy is high; parser requests wait until the fill completes.
REQ-018 Read response: the requester's rvalid is high exactly 1 cycle after its read grant, with rdata = ram_rdata; writes produce no rvalid.
REQ-019 Fill FSM states are IDLE and FILL; fill_start in IDLE latches base, count and data.
REQ-020 On fill_start in IDLE, the FSM enters FILL, or pulses fill_done the next cycle if count = 0.
REQ-021 In FILL, each fill slot writes fill_data to the current address, increments the address modulo 2^ADDR_W, and decrements the remaining count.
REQ-022 When the last fill write is issued, the FSM returns to IDLE and fill_done pulses the following cycle.
REQ-023 fill_busy is high in FILL only.
REQ-024 fill_start while the FSM is in FILL is ignored.
REQ-025 A simultaneous fill_start and prs_req in IDLE: the parser is not granted in that cycle, and fill takes effect.

Reset
REQ-026 In the cycle after rst, all gnt, rvalid, ram_en, ram_we, fill_busy and fill_done outputs are 0; rdata, ram_addr and ram_wdata are 0; the FSM is in IDLE; the starvation counter is 0.
REQ-027 Reset during FILL aborts the fill with no fill_done and drops any pending rvalid.

Configuration
REQ-028 Macro TEXT_RAM_ARB_FAIRNESS_EN defined: a counter tracks consecutive display grants while a fill or an eligible parser request is pending.
REQ-029 With the macro defined, when the counter reaches STARVE_LIMIT the next cycle's slot goes to fill or the parser (fill first), and the counter clears on any non-display grant or when nothing is pending.
REQ-030 Macro undefined: strict priority; the display can starve the other requesters indefinitely, and no counter logic is present.

Verification
REQ-031 Parser read of addr 0x005 (RAM holds 0xA5) with disp_req low -> prs_gnt in cycle 0, prs_rvalid and rdata = 0xA5 in cycle 1.
REQ-032 disp_req and a prs_req write requested in the same cycle -> disp_gnt first, prs_gnt next cycle, and RAM written once.
REQ-033 fill_start base 0xFFE, count 4, data 0x20 -> writes to 0xFFE, 0xFFF, 0x000, 0x001; fill_done 1 cycle after the last write; the parser is held off throughout.
REQ-034 fill_count 0 -> no RAM writes, fill_done the next cycle, fill_busy never high.
REQ-035 FAIRNESS_EN defined, disp_req held high continuously and prs_req pending -> prs_gnt after exactly 4 disp_gnts; macro undefined -> prs_gnt never asserted.
REQ-036 rst asserted after the 2nd write of an 8-cell fill -> no further writes, no fill_done, and all outputs 0 the next cycle.
